count_seq_monitor: RTL and testbench
====================================

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

Interface
REQ-001 The block SHALL have parameter W, default 11, as the count width.
REQ-002 The block SHALL have parameter WRAP, default 200, as the highest legal count value.
REQ-003 The block SHALL have parameter RESTART, default 1, as the value that follows WRAP.
REQ-004 The block SHALL have parameter ERR_LIMIT, default 3, as the number of consecutive mismatches that causes FAULT.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 c_in  input  W  count sample from the upstream wrap counter, sampled every clk.
REQ-008 clr_err  input  1  request to clear faults and error counts.
REQ-009 locked  output  1  high while in TRACK.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 seq_err  output  1  one-cycle pulse on a sequence mismatch.
REQ-012 range_err  output  1  one-cycle pulse on c_in > WRAP.
REQ-013 period_cnt  output  16  completed wrap periods; saturates at 16'hFFFF.
REQ-014 err_cnt  output  8  total mismatches; saturates at 8'hFF.

Function
REQ-015 The block SHALL hold registers prev (W bits), prev_vld (1 bit) and run (mismatch run count, width covering ERR_LIMIT), plus FSM states SYNC, TRACK and FAULT.
REQ-016 exp SHALL equal RESTART when prev == WRAP, else prev+1, computed in W bits.
REQ-017 Every non-reset cycle SHALL load prev <= c_in and prev_vld <= 1.
REQ-018 All outputs SHALL be registered, with 1-cycle latency from the c_in sample to its flag.
REQ-019 In SYNC, the FSM SHALL go to TRACK when prev_vld = 1 and c_in == exp; no errors SHALL be counted in SYNC.
REQ-020 In TRACK, when c_in == exp, the block SHALL clear run to 0 and take no error action.
REQ-021 In TRACK, a match with prev == WRAP and c_in == RESTART SHALL increment period_cnt, saturating.
REQ-022 In TRACK, c_in == 0 SHALL be treated as an upstream reset: the FSM goes to SYNC, run is cleared, and no error is raised.
REQ-023 In TRACK, any other c_in != exp SHALL pulse seq_err, increment err_cnt (saturating) and increment run.
REQ-024 In TRACK, when run reaches ERR_LIMIT on that mismatch, the FSM SHALL go to FAULT.
REQ-025 In TRACK, a mismatch with c_in > WRAP SHALL additionally pulse range_err.
REQ-026 range_err SHALL also pulse in SYNC when c_in > WRAP, with no count and no state change.
REQ-027 FAULT SHALL be held until clr_err; c_in SHALL be ignored for counting and period_cnt SHALL be frozen.
REQ-028 clr_err = 1 in any state SHALL force SYNC, clear err_cnt and run, and suppress seq_err and range_err that cycle.
REQ-029 clr_err SHALL NOT clear period_cnt.
REQ-030 Priority SHALL be rst > clr_err > mismatch or wrap logic.
REQ-031 Held value (c_in == prev) in TRACK SHALL be a mismatch.

Reset
REQ-032 On rst = 1 at a clock edge, the block SHALL enter SYNC with prev = 0, prev_vld = 0, run = 0, period_cnt = 0, err_cnt = 0, and locked, fault, seq_err and range_err = 0.
REQ-033 rst SHALL abort any state, including FAULT, at that edge.
REQ-034 The first post-reset sample SHALL only load prev.

Verification
REQ-035 Reset, then drive c_in 0,1,2,...,200,1,2: locked SHALL rise 1 cycle after the sample 1; period_cnt SHALL become 1 one cycle after the second 1; err_cnt SHALL stay 0.
REQ-036 In TRACK at 57, drive 59 then 60: seq_err SHALL pulse once (for 59), err_cnt SHALL be 1, locked SHALL remain 1, run SHALL return to 0.
REQ-037 In TRACK, drive 300, 5, 9 (three mismatches): range_err SHALL pulse once, seq_err SHALL pulse three times, err_cnt SHALL be 3, and fault = 1 / locked = 0 one cycle after 9.
REQ-038 In FAULT, assert clr_err for 1 cycle while c_in = 42, then drive 43: fault SHALL drop, err_cnt SHALL be 0, locked SHALL return 1 cycle after 43, period_cnt SHALL be unchanged.
REQ-039 In TRACK at 120, drive c_in = 0, then 1: no seq_err, state SHALL go to SYNC then TRACK.
REQ-040 Assert rst mid-TRACK with period_cnt = 5: all outputs SHALL be 0 the next cycle.

Source files
------------

// File: rtl/count_seq_monitor_if.sv
// Bundles the count sample, error clear and status outputs of count_seq_monitor.
// The master drives the sample and the clear; the slave (the monitor) drives the status.
interface count_seq_monitor_if #(
    parameter int W = 11
);
    logic [W-1:0] c_in;
    logic         clr_err;
    logic         locked;
    logic         fault;
    logic         seq_err;
    logic         range_err;
    logic [15:0]  period_cnt;
    logic [7:0]   err_cnt;

    modport master (
        output c_in, clr_err,
        input  locked, fault, seq_err, range_err, period_cnt, err_cnt
    );

    modport slave (
        input  c_in, clr_err,
        output locked, fault, seq_err, range_err, period_cnt, err_cnt
    );
endinterface

// File: rtl/count_seq_monitor.sv
// Watches an upstream wrap counter: locks onto its sequence, flags skips and
// out-of-range samples, counts completed periods, and latches a fault after repeated errors.
module count_seq_monitor #(
    parameter int W         = 11,
    parameter int WRAP      = 200,
    parameter int RESTART   = 1,
    parameter int ERR_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    count_seq_monitor_if.slave mon
);
    localparam int RW = $clog2(ERR_LIMIT + 1);
    localparam logic [W-1:0] WRAP_V    = W'(WRAP);
    localparam logic [W-1:0] RESTART_V = W'(RESTART);

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   prev;
    logic           prev_vld;
    logic [RW-1:0]  run_q, run_d;
    logic [15:0]    pcnt_q, pcnt_d;
    logic [7:0]     ecnt_q, ecnt_d;
    logic           seq_q, seq_d;
    logic           rng_q, rng_d;
    logic [W-1:0]   exp_v;
    logic           over;

    assign exp_v = (prev == WRAP_V) ? RESTART_V : prev + W'(1);
    assign over  = mon.c_in > WRAP_V;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        pcnt_d  = pcnt_q;
        ecnt_d  = ecnt_q;
        seq_d   = 1'b0;
        rng_d   = 1'b0;
        if (mon.clr_err) begin
            state_d = SYNC;
            run_d   = '0;
            ecnt_d  = '0;
        end else begin
            unique case (state_q)
                SYNC: begin
                    // Nothing is judged until a previous sample exists.
                    if (prev_vld) begin
                        rng_d = over;
                        if (mon.c_in == exp_v) state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (mon.c_in == exp_v) begin
                        run_d = '0;
                        if (prev == WRAP_V && pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
                    end else if (mon.c_in == '0) begin
                        // Upstream counter was reset: resynchronise quietly.
                        state_d = SYNC;
                        run_d   = '0;
                    end else begin
                        seq_d = 1'b1;
                        rng_d = over;
                        run_d = run_q + RW'(1);
                        if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
                        if (int'(run_q) + 1 >= ERR_LIMIT) state_d = FAULT;
                    end
                end
                FAULT: ;
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SYNC;
            prev     <= '0;
            prev_vld <= 1'b0;
            run_q    <= '0;
            pcnt_q   <= '0;
            ecnt_q   <= '0;
            seq_q    <= 1'b0;
            rng_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev     <= mon.c_in;
            prev_vld <= 1'b1;
            run_q    <= run_d;
            pcnt_q   <= pcnt_d;
            ecnt_q   <= ecnt_d;
            seq_q    <= seq_d;
            rng_q    <= rng_d;
        end
    end

    assign mon.locked     = (state_q == TRACK);
    assign mon.fault      = (state_q == FAULT);
    assign mon.seq_err    = seq_q;
    assign mon.range_err  = rng_q;
    assign mon.period_cnt = pcnt_q;
    assign mon.err_cnt    = ecnt_q;
endmodule

// File: tb/tb_count_seq_monitor.sv
// Randomised plus directed bench for count_seq_monitor; a driver pushes model
// predictions into a queue and an independent monitor pops and compares.
module tb_count_seq_monitor;
    localparam int W = 11, WRAP = 200, RESTART = 1, ERR_LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count_seq_monitor_if #(.W(W)) bus ();

    count_seq_monitor #(.W(W), .WRAP(WRAP), .RESTART(RESTART), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk(clk), .rst(rst), .mon(bus.slave)
    );

    typedef struct {
        bit        locked, fault, seq_err, range_err;
        int        period_cnt, err_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    bit   drive_done = 0;

    // Reference model: plain behavioural state
    int  m_prev, m_run, m_pc, m_ec;
    bit  m_have_prev, m_locked, m_fault;

    function automatic int next_of(int v);
        return (v == WRAP) ? RESTART : (v + 1) % (1 << W);
    endfunction

    function automatic exp_t model(int c, bit clr, bit r);
        exp_t e;
        bit seq = 0, rng = 0;
        if (r) begin
            m_prev = 0; m_have_prev = 0; m_run = 0; m_pc = 0; m_ec = 0;
            m_locked = 0; m_fault = 0;
        end else begin
            if (clr) begin
                m_locked = 0; m_fault = 0; m_run = 0; m_ec = 0;
            end else if (m_fault) begin
            end else if (m_locked) begin
                if (c == next_of(m_prev)) begin
                    m_run = 0;
                    if (m_prev == WRAP) m_pc = (m_pc < 65535) ? m_pc + 1 : 65535;
                end else if (c == 0) begin
                    m_locked = 0; m_run = 0;
                end else begin
                    seq = 1; rng = (c > WRAP);
                    m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                    m_run++;
                    if (m_run >= ERR_LIMIT) begin m_locked = 0; m_fault = 1; end
                end
            end else if (m_have_prev) begin
                rng = (c > WRAP);
                if (c == next_of(m_prev)) m_locked = 1;
            end
            m_prev = c; m_have_prev = 1;
        end
        e.locked = m_locked; e.fault = m_fault; e.seq_err = seq; e.range_err = rng;
        e.period_cnt = m_pc; e.err_cnt = m_ec;
        return e;
    endfunction

    task automatic drive(int c, bit clr = 0, bit r = 0);
        @(negedge clk);
        bus.c_in    = W'(c);
        bus.clr_err = clr;
        rst         = r;
        exp_q.push_back(model(c, clr, r));
    endtask

    int cur;
    task automatic count_to(int target);
        while (cur != target) begin
            cur = next_of(cur);
            drive(cur);
        end
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // Monitor: outputs are valid every cycle, one cycle after the sample
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("locked",     int'(bus.locked),    int'(e.locked));
                chk("fault",      int'(bus.fault),     int'(e.fault));
                chk("seq_err",    int'(bus.seq_err),   int'(e.seq_err));
                chk("range_err",  int'(bus.range_err), int'(e.range_err));
                chk("period_cnt", int'(bus.period_cnt), e.period_cnt);
                chk("err_cnt",    int'(bus.err_cnt),   e.err_cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int r, v;
        bus.c_in = '0; bus.clr_err = 1'b0;
        drive(0, 0, 1);
        drive(0, 0, 1);
        // Lock, one full period, then a single skip
        cur = 0; drive(0);
        count_to(WRAP); count_to(2);
        count_to(57); drive(59); drive(60); cur = 60;
        // Three mismatches in a row, including one out of range
        count_to(80); drive(300); drive(5); drive(9);
        drive(10); drive(11);
        drive(42, 1); drive(43); cur = 43;
        count_to(120); drive(0); drive(1); cur = 1;
        // Accumulate five periods, then reset mid-track
        for (int p = 0; p < 4; p++) begin count_to(WRAP); count_to(RESTART); end
        count_to(30); drive(31, 0, 1); cur = 31; drive(cur);
        // Random phase
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 160) begin cur = next_of(cur); drive(cur); end
            else if (r < 172) begin cur = $urandom_range(1, WRAP); drive(cur); end
            else if (r < 178) begin cur = 0; drive(0); end
            else if (r < 186) begin v = $urandom_range(WRAP + 1, (1 << W) - 1); drive(v); cur = $urandom_range(1, WRAP); end
            else if (r < 191) drive(cur);
            else if (r < 197) begin cur = next_of(cur); drive(cur, 1); end
            else if (r < 199) begin cur = next_of(cur); drive(cur, $urandom_range(0, 1) == 1); end
            else begin cur = 0; drive(0, 0, 1); end
        end
        @(negedge clk); rst = 1'b0;
        drive_done = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
